// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//
// Pipeline-stage register placed between two CPU pipeline stages. It carries
// a payload under a valid/ready handshake, with an optional skid entry
// (DEPTH=2) that keeps in_ready free of any combinational path from
// out_ready. Also provides:
//   - bubble: inserts an empty slot downstream while holding upstream.
//   - flush:  kills every held payload.
//   - a side channel (PC-like) that keeps advancing with the slot even when
//     the payload is killed or is a bubble.
//
// Parameters
//   DATA_W       payload width
//   SIDE_W       side-channel width
//   DEPTH        1 or 2 entries (2 adds the skid entry)
//   ZERO_BUBBLE  1: out_data reads 0 whenever out_valid is 0
//                0: out_data holds its last value
//
// Ports
//   clk, cpurst_n         clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_data, in_side      upstream payload and side value
//   bubble, flush         slot controls
//   out_valid/out_ready   downstream handshake on the main entry
//   out_data, out_side    main-entry payload and side value
//   occupancy             number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned SIDE_W      = 32,
    parameter int unsigned DEPTH       = 2,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              cpurst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIDE_W-1:0] in_side,

    input  logic              bubble,
    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SIDE_W-1:0] out_side,

    output logic [1:0]        occupancy
);

    // Only one- and two-entry buffers are meaningful.
    if ((DEPTH != 1) && (DEPTH != 2)) begin : g_depth_check
        $error("pipe_stage_buf: DEPTH must be 1 or 2");
    end

    localparam bit HAS_SKID = (DEPTH == 2);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SIDE_W-1:0] side;
    } entry_t;

    logic   main_valid_q, main_valid_d;
    entry_t main_q,       main_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t skid_q,       skid_d;
    logic [1:0] occ_q,    occ_d;

    logic advance_c;
    logic accept_c;

    // Main entry can take a new value when empty or when it leaves this cycle.
    assign advance_c = !main_valid_q || out_ready;

    // With a skid entry, readiness depends only on registered state, so
    // upstream never sees a combinational path from out_ready.
    always_comb begin
        if (HAS_SKID) begin
            in_ready = !skid_valid_q && !bubble && !flush;
        end else begin
            in_ready = advance_c && !bubble && !flush;
        end
    end

    assign accept_c = in_valid && in_ready;

    // Next-state: flush beats skid drain, which beats a fresh accept.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (ZERO_BUBBLE) begin
                main_d.data = '0;
                skid_d      = '0;
            end
            // The slot still moves on, so its side value follows upstream.
            if (advance_c) begin
                main_d.side = in_side;
            end
        end else if (advance_c) begin
            if (skid_valid_q) begin
                // Oldest payload lives in the skid; promote it first.
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept_c;
                // Side tracks the slot regardless of in_valid or bubble.
                main_d.side  = in_side;
                if (accept_c) begin
                    main_d.data = in_data;
                end else if (ZERO_BUBBLE) begin
                    main_d.data = '0;
                end
            end
        end else if (HAS_SKID && accept_c) begin
            // Main entry stalled: park the incoming payload in the skid.
            skid_valid_d = 1'b1;
            skid_d.data  = in_data;
            skid_d.side  = in_side;
        end

        occ_d = 2'(main_valid_d) + 2'(skid_valid_d);
    end

    // State register.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            occ_q        <= 2'd0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            occ_q        <= occ_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_q.data;
    assign out_side  = main_q.side;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buf
//
// Three builds share one stimulus stream: DEPTH=2/ZERO_BUBBLE=1,
// DEPTH=1/ZERO_BUBBLE=1 and DEPTH=2/ZERO_BUBBLE=0. A queue-level reference
// model tracks each build; accepted payloads go to per-build scoreboards that
// a monitor branch drains whenever the DUT hands one downstream.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 16;
    localparam int unsigned NDUT = 3;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] side;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [SW-1:0] in_side;
    logic          bubble;
    logic          flush;
    logic          out_ready;

    logic          ir  [NDUT];
    logic          ov  [NDUT];
    logic [DW-1:0] od  [NDUT];
    logic [SW-1:0] os  [NDUT];
    logic [1:0]    occ [NDUT];

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .DEPTH(2), .ZERO_BUBBLE(1'b1)) u_d2 (
        .clk(clk), .cpurst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_side(in_side),
        .bubble(bubble), .flush(flush),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_side(os[0]),
        .occupancy(occ[0])
    );

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .DEPTH(1), .ZERO_BUBBLE(1'b1)) u_d1 (
        .clk(clk), .cpurst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_side(in_side),
        .bubble(bubble), .flush(flush),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_side(os[1]),
        .occupancy(occ[1])
    );

    pipe_stage_buf #(.DATA_W(DW), .SIDE_W(SW), .DEPTH(2), .ZERO_BUBBLE(1'b0)) u_d2h (
        .clk(clk), .cpurst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data), .in_side(in_side),
        .bubble(bubble), .flush(flush),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_side(os[2]),
        .occupancy(occ[2])
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: held payloads as a queue (front = main entry).
    ent_t          mq  [NDUT][$];
    ent_t          sbq [NDUT][$];
    logic [DW-1:0] m_data [NDUT];
    logic [SW-1:0] m_side [NDUT];
    bit            s_mov  [NDUT];
    bit            s_adv  [NDUT];
    bit            s_acc  [NDUT];

    function automatic int dep(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic bit zb(input int k);
        return (k != 2);
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            mq[k].delete();
            sbq[k].delete();
            m_data[k] = '0;
            m_side[k] = '0;
        end
    endtask

    // One clock cycle: drive, check state and readiness, then advance the model.
    task automatic step(input bit iv, input logic [DW-1:0] id, input logic [SW-1:0] is,
                        input bit bub, input bit fl, input bit ordy);
        ent_t e;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        in_side   = is;
        bubble    = bub;
        flush     = fl;
        out_ready = ordy;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            int sz;
            bit mrdy;
            sz       = mq[k].size();
            s_mov[k] = (sz > 0);
            s_adv[k] = !s_mov[k] || ordy;
            if (dep(k) == 1) mrdy = s_adv[k] && !bub && !fl;
            else             mrdy = (sz < 2) && !bub && !fl;
            s_acc[k] = iv && mrdy;

            check("out_valid", k, 64'(ov[k]), 64'(s_mov[k]));
            check("occupancy", k, 64'(occ[k]), 64'(sz));
            check("out_data",  k, 64'(od[k]), 64'(m_data[k]));
            check("out_side",  k, 64'(os[k]), 64'(m_side[k]));
            check("in_ready",  k, 64'(ir[k]), 64'(mrdy));

            if (fl) begin
                // Everything not consumed by downstream this cycle is killed.
                int kill;
                kill = sz - ((s_mov[k] && ordy) ? 1 : 0);
                repeat (kill) void'(sbq[k].pop_back());
            end else if (s_acc[k]) begin
                e.data = id;
                e.side = is;
                sbq[k].push_back(e);
            end
        end
        @(posedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (fl) begin
                mq[k].delete();
                if (zb(k)) m_data[k] = '0;
                if (s_adv[k]) m_side[k] = is;
            end else begin
                bit skid_full;
                skid_full = (mq[k].size() == 2);
                if (s_mov[k] && ordy) void'(mq[k].pop_front());
                if (s_acc[k]) begin
                    e.data = id;
                    e.side = is;
                    mq[k].push_back(e);
                end
                if (s_adv[k]) m_side[k] = skid_full ? mq[k][0].side : is;
                if (mq[k].size() > 0) m_data[k] = mq[k][0].data;
                else if (zb(k))      m_data[k] = '0;
            end
        end
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic async_reset();
        #3;
        in_valid = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_out_valid", k, 64'(ov[k]), 64'd0);
            check("rst_occupancy", k, 64'(occ[k]), 64'd0);
            check("rst_out_data",  k, 64'(od[k]), 64'd0);
            check("rst_out_side",  k, 64'(os[k]), 64'd0);
            check("rst_in_ready",  k, 64'(ir[k]), 64'd1);
        end
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        in_side   = '0;
        bubble    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();

        // Monitor: pops the scoreboard whenever a DUT hands a payload out.
        fork
            forever begin
                @(negedge clk);
                #2;
                if (rst_n) begin
                    for (int k = 0; k < NDUT; k++) begin
                        if (ov[k] && out_ready) begin
                            if (sbq[k].size() == 0) begin
                                check("unexpected_out_valid", k, 64'(ov[k]), 64'd0);
                            end else begin
                                ent_t e;
                                e = sbq[k].pop_front();
                                check("sb_data", k, 64'(od[k]), 64'(e.data));
                                check("sb_side", k, 64'(os[k]), 64'(e.side));
                            end
                        end
                    end
                end
            end
        join_none

        #2;
        for (int k = 0; k < NDUT; k++) begin
            check("init_out_valid", k, 64'(ov[k]), 64'd0);
            check("init_occupancy", k, 64'(occ[k]), 64'd0);
            check("init_in_ready",  k, 64'(ir[k]), 64'd1);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Streaming with downstream always ready.
        step(1'b1, 32'h11, 16'h100, 1'b0, 1'b0, 1'b1);
        #1 check("stream_first", 0, 64'(od[0]), 64'h11);
        step(1'b1, 32'h22, 16'h101, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h33, 16'h102, 1'b0, 1'b0, 1'b1);
        #1 check("stream_third", 0, 64'(od[0]), 64'h33);
        check("stream_occ", 0, 64'(occ[0]), 64'd1);
        check("stream_side", 0, 64'(os[0]), 64'h102);
        step(1'b0, 32'h0, 16'h103, 1'b0, 1'b0, 1'b1);

        // Backpressure: skid fills on DEPTH=2, DEPTH=1 refuses in the same cycle.
        step(1'b1, 32'hA1, 16'h200, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hA2, 16'h201, 1'b0, 1'b0, 1'b0);
        #1 check("full_occ", 0, 64'(occ[0]), 64'd2);
        check("full_in_ready", 0, 64'(ir[0]), 64'd0);
        check("d1_stall_in_ready", 1, 64'(ir[1]), 64'd0);
        check("d1_hold", 1, 64'(od[1]), 64'hA1);
        step(1'b1, 32'hA2, 16'h201, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hA2, 16'h201, 1'b0, 1'b0, 1'b1);
        #1 check("skid_drain", 0, 64'(od[0]), 64'hA2);
        step(1'b0, 32'h0, 16'h202, 1'b0, 1'b0, 1'b1);

        // Bubble inside a stream.
        step(1'b1, 32'h44, 16'h300, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h55, 16'h301, 1'b1, 1'b0, 1'b1);
        #1 check("bubble_valid", 0, 64'(ov[0]), 64'd0);
        check("bubble_data", 0, 64'(od[0]), 64'd0);
        check("bubble_side", 0, 64'(os[0]), 64'h301);
        step(1'b1, 32'h55, 16'h302, 1'b0, 1'b0, 1'b1);
        #1 check("after_bubble", 0, 64'(od[0]), 64'h55);
        step(1'b0, 32'h0, 16'h303, 1'b0, 1'b0, 1'b1);

        // Flush with two entries held.
        step(1'b1, 32'hC1, 16'h400, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hC2, 16'h401, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC3, 16'h402, 1'b0, 1'b1, 1'b0);
        #1 check("flush_valid", 0, 64'(ov[0]), 64'd0);
        check("flush_occ", 0, 64'(occ[0]), 64'd0);
        check("flush_zero", 0, 64'(od[0]), 64'd0);
        check("flush_hold", 2, 64'(od[2]), 64'hC1);
        step(1'b0, 32'h0, 16'h403, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during a stall.
        step(1'b1, 32'hD1, 16'h500, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'hD2, 16'h501, 1'b0, 1'b0, 1'b0);
        async_reset();
        step(1'b1, 32'hE1, 16'h600, 1'b0, 1'b0, 1'b1);
        #1 check("post_reset_data", 0, 64'(od[0]), 64'hE1);
        check("post_reset_valid", 1, 64'(ov[1]), 64'd1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 9) < 7, DW'($urandom), SW'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6);
        end

        // Drain and confirm nothing is left undelivered.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        #3;
        for (int k = 0; k < NDUT; k++) begin
            check("drained_valid", k, 64'(ov[k]), 64'd0);
            check("sb_drained", k, 64'(sbq[k].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register, next generation of the EX/MEM-style stage latch.
- Replaces the implicit stall/NOP scheme with a valid/ready handshake, an optional skid entry, explicit bubble and flush controls, and a separate side channel (PC-like) that keeps advancing when the payload is killed.
- Instantiated between any two CPU pipeline stages.

Parameters:
- DATA_W, 64: payload width (packed control and data fields of the stage).
- SIDE_W, 32: side-channel width (e.g. instruction PC), never zeroed by flush or bubble.
- DEPTH, 2: entries, 1 or 2. With 2, a skid entry gives a registered in_ready. Other values are a compile-time error.
- ZERO_BUBBLE, 1: 1 zeroes out_data whenever out_valid is 0; 0 lets out_data hold its last value.

Ports:
- clk  in  1  stage clock; all state on rising edge.
- cpurst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts this cycle.
- in_data  in  DATA_W  upstream payload.
- in_side  in  SIDE_W  upstream side value.
- bubble  in  1  insert an empty slot (downstream-side NOP); upstream is held.
- flush  in  1  kill all held payloads (exception / redirect).
- out_valid  out  1  main entry holds a payload.
- out_ready  in  1  downstream consumes the main entry.
- out_data  out  DATA_W  main-entry payload.
- out_side  out  SIDE_W  main-entry side value.
- occupancy  out  2  number of valid entries, 0..DEPTH.

Behaviour:
- Reset (cpurst_n=0, asynchronous):
  - main_valid=0, skid_valid=0, out_data=0, out_side=0, occupancy=0.
  - Reset mid-transfer drops all held payloads.
- Definitions:
  - advance = !out_valid | out_ready.
  - accept = in_valid & in_ready.
- in_ready:
  - DEPTH=1: advance & !bubble & !flush (combinational from out_ready).
  - DEPTH=2: !skid_valid & !bubble & !flush (no combinational path from out_ready).
  - Reset state: in_ready=1 when bubble=flush=0.
- Priority per cycle: flush > skid drain > accept.
- flush=1:
  - Next cycle: main_valid=0, skid_valid=0, occupancy=0.
  - Payload registers load 0. If ZERO_BUBBLE=0, they hold their value instead.
  - Any same-cycle input is not accepted (in_ready=0).
  - If advance, out_side loads in_side.
- advance=1, flush=0:
  - If skid_valid: main <= skid (data and side), skid_valid <= 0.
  - Else: main_valid <= accept. On accept, out_data <= in_data; otherwise out_data <= 0 (ZERO_BUBBLE=1) or holds.
  - In both cases, out_side <= in_side whenever skid is empty, independent of in_valid and bubble (side tracks the slot, matching the stage-PC convention).
- advance=0, flush=0 (out_valid & !out_ready):
  - Main entry and out_side hold.
  - DEPTH=2 with accept: skid <= {in_data, in_side}, skid_valid <= 1.
- bubble=1: no accept that cycle. The main entry still drains; with nothing to refill it, out_valid goes 0 next cycle (the NOP).
- Latency: 1 cycle in_data to out_data when skid is empty; the skid adds no latency beyond waiting for out_ready.
- No payload is ever duplicated or dropped except by flush or reset.
- occupancy = main_valid + skid_valid, registered.
- Full boundary: with DEPTH=2 and occupancy=2, in_ready=0. It returns to 1 the cycle after out_ready is seen.
- Empty boundary: out_valid=0, and out_data=0 when ZERO_BUBBLE=1.
- Simultaneous flush and out_ready: the main entry counts as consumed by downstream this cycle; the skid entry is discarded.

Test Plan:
- Reset then stream: in_data=0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each; occupancy stays 1; out_side follows in_side.
- Backpressure, DEPTH=2:
  - out_ready=0 with 0xA1 held, 0xA2 presented -> skid captures 0xA2, occupancy=2, in_ready=0.
  - Then out_ready=1 -> 0xA1 then 0xA2 delivered, no loss or duplication.
- DEPTH=1 backpressure: out_ready=0 -> in_ready=0 in the same cycle; 0xB1 held until out_ready=1.
- Bubble: bubble=1 for one cycle in a stream with in_valid=1, in_data=0x55 -> 0x55 not accepted; out_valid=0 and out_data=0 for one cycle; out_side=in_side of that cycle; 0x55 delivered next.
- Flush with occupancy=2 (payloads 0xC1, 0xC2) -> next cycle out_valid=0, occupancy=0, out_data=0; same-cycle in_data=0xC3 not accepted; ZERO_BUBBLE=0 build shows out_data held.
- Async reset: assert cpurst_n=0 mid-stall between clock edges -> out_valid, occupancy, out_data, out_side go to 0 immediately; on release, first accepted payload appears 1 cycle later.
